// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if : byte stream in, shared memory write port out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, mem_we, mem_addr, mem_data
  );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader : streams a byte image into instruction/data memory,
//                    pads it to a word boundary, then releases the pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_boot_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [3:0] C_HOLD = 4'(HOLD_CYCLES);

  state_t            r_state;
  state_t            w_next;
  // One bit wider than the memory address so "full" is representable without wrapping
  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W:0]   w_addr_next;
  logic [3:0]        r_hold;
  logic [3:0]        w_hold_next;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_ovf;
  logic [ADDR_W-2:0] r_wcount;

  logic              w_full;
  logic              w_accept;
  logic              w_we;
  logic [7:0]        w_data;
  logic              w_ovf_set;
  logic              w_clear;

  assign w_full   = r_addr[ADDR_W];
  assign w_accept = bus.byte_valid & r_ready;

  always_comb begin
    w_next      = r_state;
    w_addr_next = r_addr;
    w_hold_next = r_hold;
    w_we        = 1'b0;
    w_data      = 8'h00;
    w_ovf_set   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_data      = bus.byte_in;
            w_addr_next = r_addr + (ADDR_W+1)'(1);
          end
          if (bus.byte_last) begin
            w_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (r_addr[1:0] != 2'b00 && !w_full) begin
          w_we        = 1'b1;
          w_addr_next = r_addr + (ADDR_W+1)'(1);
        end else begin
          w_next      = ST_HOLD;
          w_hold_next = C_HOLD;
        end
      end
      ST_HOLD: begin
        w_hold_next = r_hold - 4'd1;
        if (r_hold <= 4'd1) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          w_next      = ST_LOAD;
          w_addr_next = '0;
          w_clear     = 1'b1;
        end
      end
      default: w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_addr     <= '0;
      r_hold     <= '0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wcount   <= '0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr_next;
      r_hold    <= w_hold_next;
      // Status outputs follow the next state so they change on the transition edge
      r_ready   <= (w_next == ST_LOAD);
      r_cpu_rst <= (w_next != ST_RUN);
      r_done    <= (w_next == ST_RUN);
      r_we      <= w_we;
      if (w_we) begin
        r_mem_addr <= r_addr[ADDR_W-1:0];
        r_mem_data <= w_data;
      end
      if (w_clear) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_clear) begin
        r_wcount <= '0;
      end else if (w_we && r_addr[1:0] == 2'b11) begin
        r_wcount <= {1'b0, r_addr[ADDR_W-1:2]} + (ADDR_W-1)'(1);
      end
    end
  end

  assign bus.byte_ready = r_ready;
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign cpu_rst        = r_cpu_rst;
  assign boot_done      = r_done;
  assign overflow       = r_ovf;
  assign word_count     = r_wcount;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader : drives one byte stream into loaders with 256-byte and
//                       16-byte address spaces and checks each against a model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_boot_loader;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;
  logic [1:0] rdy;
  logic [1:0] done;

  logic [7:0] img[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AW    = (g == 0) ? 8 : 4;
    localparam int DEPTH = 1 << AW;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();
    logic          cpu_rst;
    logic          boot_done;
    logic          overflow;
    logic [AW-2:0] word_count;

    assign bus.byte_in    = byte_in;
    assign bus.byte_valid = byte_valid;
    assign bus.byte_last  = byte_last;
    assign rdy[g]         = bus.byte_ready;
    assign done[g]        = boot_done;

    imem_boot_loader #(.ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus),
      .cpu_rst    (cpu_rst),
      .boot_done  (boot_done),
      .overflow   (overflow),
      .word_count (word_count)
    );

    logic [7:0] wmem [DEPTH];
    logic [7:0] acc_byte;
    int         n_acc, n_wr, acc_idx, cyc, last_we;
    bit         acc_prev, start_prev, done_prev;

    task automatic clear_image();
      n_acc = 0;
      n_wr  = 0;
      for (int i = 0; i < DEPTH; i++) wmem[i] = 8'bx;
    endtask

    // Outputs must drop to reset values between clock edges
    always @(negedge rst_n) begin
      #1;
      chk("rst_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst_we",    32'(bus.mem_we),     32'd0);
      chk("rst_addr",  32'(bus.mem_addr),   32'd0);
      chk("rst_data",  32'(bus.mem_data),   32'd0);
      chk("rst_cpu",   32'(cpu_rst),        32'd1);
      chk("rst_done",  32'(boot_done),      32'd0);
      chk("rst_ovf",   32'(overflow),       32'd0);
      chk("rst_wcnt",  32'(word_count),     32'd0);
    end

    always @(negedge clk) begin
      int n, nw, pe;
      cyc++;
      if (!rst_n) begin
        clear_image();
        acc_prev   = 1'b0;
        start_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (start_prev) begin
          chk("start_done", 32'(boot_done),  32'd0);
          chk("start_cpu",  32'(cpu_rst),    32'd1);
          chk("start_ovf",  32'(overflow),   32'd0);
          chk("start_wcnt", 32'(word_count), 32'd0);
          clear_image();
        end
        if (acc_prev) begin
          if (acc_idx < DEPTH) begin
            chk("lat_we",   32'(bus.mem_we),   32'd1);
            chk("lat_addr", 32'(bus.mem_addr), 32'(acc_idx));
            chk("lat_data", 32'(bus.mem_data), 32'(acc_byte));
          end else begin
            chk("ovf_we", 32'(bus.mem_we), 32'd0);
          end
        end else if (bus.mem_we) begin
          chk("pad_ready", 32'(bus.byte_ready), 32'd0);
        end
        if (bus.mem_we) begin
          wmem[bus.mem_addr] = bus.mem_data;
          n_wr++;
          last_we = cyc;
        end
        if (boot_done && !done_prev) begin
          n  = img.size();
          nw = (n < DEPTH) ? n : DEPTH;
          pe = ((nw + 3) / 4) * 4;
          chk("accepted", 32'(n_acc), 32'(n));
          chk("writes",   32'(n_wr),  32'(pe));
          for (int i = 0; i < pe; i++)
            chk("image", {16'(i), 8'h00, wmem[i]}, {16'(i), 8'h00, (i < nw) ? img[i] : 8'h00});
          chk("wcnt",     32'(word_count), 32'(pe / 4));
          chk("overflow", 32'(overflow),   32'(n > DEPTH));
          chk("cpu_rst",  32'(cpu_rst),    32'd0);
          // Final write occupies one cycle, then HOLD cycles elapse before release
          if (n <= DEPTH) chk("hold", 32'(cyc - last_we), 32'(HOLD + 1));
        end
        done_prev  = boot_done;
        acc_prev   = byte_valid && bus.byte_ready;
        if (acc_prev) begin
          acc_byte = byte_in;
          acc_idx  = n_acc;
          n_acc++;
        end
        start_prev = start && boot_done;
      end
    end
  end

  // Sends img[0 .. n_send-1]; gap: 0 = always valid, 1 = alternate, 2 = random
  task automatic send_image(input int n_send, input int gap, input bit noise);
    int i = 0;
    int t = 0;
    while (i < n_send && t < 400) begin
      @(posedge clk); #1;
      byte_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (t % 2 == 0) : ($urandom_range(0, 2) != 0);
      byte_in    = byte_valid ? img[i] : 8'($urandom);
      byte_last  = byte_valid ? (i == img.size() - 1) : 1'($urandom);
      start      = noise && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (byte_valid && rdy[0]) i++;
      t++;
    end
    if (i < n_send) chk("send_timeout", 32'(i), 32'(n_send));
    @(posedge clk); #1;
    start = 1'b0;
    if (n_send == img.size()) begin
      // Stray bytes after the last one must be ignored
      byte_valid = 1'b1;
      byte_last  = 1'b1;
      byte_in    = 8'hEE;
      repeat (2) @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_boot();
    int t = 0;
    while (!(done[0] && done[1]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("boot_timeout", 32'(done[0] && done[1]), 32'd1);
  endtask

  task automatic restart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic rand_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    img = '{8'h81, 8'hC0, 8'h20, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_image(8, 0, 1'b0);
    wait_boot();

    restart();
    img = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_image(6, 0, 1'b0);
    wait_boot();

    restart();
    rand_image(18);
    send_image(18, 0, 1'b0);
    wait_boot();

    restart();
    rand_image(4);
    send_image(4, 1, 1'b0);
    wait_boot();

    restart();
    img = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    send_image(4, 0, 1'b0);
    wait_boot();

    // Asynchronous reset in the middle of a load
    restart();
    rand_image(6);
    send_image(3, 0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_image(5);
    send_image(5, 2, 1'b0);
    wait_boot();

    for (int k = 0; k < 12; k++) begin
      restart();
      rand_image($urandom_range(1, 22));
      send_image(img.size(), 2, 1'b1);
      wait_boot();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
